// File: rtl/vector_issue_unit.sv
// Issue/writeback sequencer: holds a vector register file, issues one instruction
// at a time to a start/busy vector ALU and writes the result back to vd.
module vector_issue_unit #(
  parameter int VLEN   = 8,
  parameter int EWIDTH = 32,
  parameter int LANES  = 2,
  parameter int NREGS  = 8,
  parameter int RW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [2:0]               instr_op,
  input  logic [RW-1:0]            instr_vd,
  input  logic [RW-1:0]            instr_vs1,
  input  logic [RW-1:0]            instr_vs2,
  input  logic                     wr_en,
  input  logic [RW-1:0]            wr_addr,
  input  logic [EWIDTH*VLEN-1:0]   wr_data,
  input  logic [RW-1:0]            rd_addr,
  output logic [EWIDTH*VLEN-1:0]   rd_data,
  output logic                     alu_start,
  output logic [2:0]               alu_op,
  output logic [EWIDTH*VLEN-1:0]   alu_src1,
  output logic [EWIDTH*VLEN-1:0]   alu_src2,
  input  logic                     alu_busy,
  input  logic [EWIDTH*VLEN-1:0]   alu_result,
  output logic                     done,
  output logic                     wr_err
);

  localparam int DW          = EWIDTH * VLEN;
  localparam int BUSY_CYCLES = (VLEN + LANES - 1) / LANES;
  localparam int CW          = $clog2(BUSY_CYCLES + 2);
  localparam logic [CW-1:0] BUSY_MAX = CW'(BUSY_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, RUN, WB} state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      op_q;
  logic [RW-1:0]   vd_q;
  logic [RW-1:0]   vs1_q;
  logic [RW-1:0]   vs2_q;
  logic [DW-1:0]   regs [NREGS];
  logic            accept;
  logic [CW-1:0]   busy_cnt;

  assign accept = (state == IDLE) && instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ARM exists so a busy that has not yet risen after start is not taken as completion.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    alu_start   = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = ISSUE;
      end
      ISSUE: begin
        alu_start = 1'b1;
        if (!alu_busy) state_next = ARM;
      end
      ARM: begin
        if (alu_busy) state_next = RUN;
      end
      RUN: begin
        if (!alu_busy) state_next = WB;
      end
      WB: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 3'b000;
      vd_q  <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
    end else if (accept) begin
      op_q  <= instr_op;
      vd_q  <= instr_vd;
      vs1_q <= instr_vs1;
      vs2_q <= instr_vs2;
    end
  end

  // Only two write windows: the loader in IDLE and the ALU result in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == WB) begin
      regs[vd_q] <= alu_result;
    end else if ((state == IDLE) && wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (wr_en && (state != IDLE)) begin
      wr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (state == ISSUE) begin
      busy_cnt <= '0;
    end else if (((state == ARM) || (state == RUN)) && alu_busy && (busy_cnt != '1)) begin
      busy_cnt <= busy_cnt + CW'(1);
    end
  end

  busy_len_bound: assert property (@(posedge clk) disable iff (!rst_n) busy_cnt <= BUSY_MAX);

  assign alu_op   = op_q;
  assign alu_src1 = regs[vs1_q];
  assign alu_src2 = regs[vs2_q];
  assign rd_data  = regs[rd_addr];

endmodule
